// File: rtl/bbox_scanner.sv
// Streams one byte-serial raster frame and reports the bounding box and count of dark (foreground) pixels.
// Result registered one cycle after the final accepted byte; no backpressure on wr_en, result held until rd_en/start.
module bbox_scanner #(
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 90,
  parameter int CHANNELS  = 3,
  parameter int THRESH    = 100,
  parameter int BOTTOM_UP = 1,
  parameter int COORD_W   = 8,
  parameter int CNT_W     = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 any_mode,
  input  logic                 rd_en,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 found,
  output logic [CNT_W-1:0]     fg_count,
  output logic [4*COORD_W-1:0] out
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAXV  = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] Y_FIRST = (BOTTOM_UP != 0) ? Y_MAXV : COORD_W'(0);
  localparam logic [COORD_W-1:0] Y_LAST  = (BOTTOM_UP != 0) ? COORD_W'(0) : Y_MAXV;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH * HEIGHT);
  localparam logic [7:0]         THR     = 8'(THRESH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                 dark_q, dark_d;
  logic [COORD_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rv_q, rv_d, found_q, found_d;
  logic [CNT_W-1:0]     fgc_q, fgc_d;
  logic [4*COORD_W-1:0] out_q, out_d;

  logic                 byte_dark, dark_acc, pix_last, row_last, frame_last, fg;
  logic [COORD_W-1:0]   nxmin, nxmax, nymin, nymax;
  logic [CNT_W-1:0]     ncnt;

  // Per-pixel dark flag restarts on channel 0 and folds in the current byte on every channel.
  assign byte_dark  = wr_data < THR;
  assign dark_acc   = (ch_q == '0) ? byte_dark :
                      (any_mode ? (dark_q | byte_dark) : (dark_q & byte_dark));
  assign pix_last   = (ch_q == CH_LAST);
  assign row_last   = (x_q == X_LAST);
  assign frame_last = pix_last && row_last && (y_q == Y_LAST);
  assign fg         = pix_last && dark_acc;

  assign nxmin = (fg && (x_q < xmin_q)) ? x_q : xmin_q;
  assign nxmax = (fg && (x_q > xmax_q)) ? x_q : xmax_q;
  assign nymin = (fg && (y_q < ymin_q)) ? y_q : ymin_q;
  assign nymax = (fg && (y_q > ymax_q)) ? y_q : ymax_q;
  assign ncnt  = (fg && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    x_d     = x_q;
    y_d     = y_q;
    dark_d  = dark_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    found_d = found_q;
    fgc_d   = fgc_q;
    out_d   = out_q;
    if (start) begin
      state_d = SCAN;
      ch_d    = '0;
      x_d     = '0;
      y_d     = Y_FIRST;
      dark_d  = 1'b0;
      xmin_d  = X_LAST;
      xmax_d  = '0;
      ymin_d  = Y_MAXV;
      ymax_d  = '0;
      cnt_d   = '0;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (wr_en) begin
            dark_d = dark_acc;
            xmin_d = nxmin;
            xmax_d = nxmax;
            ymin_d = nymin;
            ymax_d = nymax;
            cnt_d  = ncnt;
            if (!pix_last) begin
              ch_d = ch_q + CH_W'(1);
            end else begin
              ch_d = '0;
              if (!row_last) begin
                x_d = x_q + COORD_W'(1);
              end else begin
                x_d = '0;
                y_d = (BOTTOM_UP != 0) ? y_q - COORD_W'(1) : y_q + COORD_W'(1);
              end
            end
            if (frame_last) begin
              state_d = DONE;
              y_d     = Y_FIRST;
              rv_d    = 1'b1;
              found_d = (ncnt != '0);
              fgc_d   = ncnt;
              out_d   = (ncnt != '0) ? {nxmin, nxmax, nymin, nymax} : '0;
            end
          end
        end
        DONE: begin
          if (rd_en) begin
            state_d = IDLE;
            rv_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      x_q     <= '0;
      y_q     <= Y_FIRST;
      dark_q  <= 1'b0;
      xmin_q  <= X_LAST;
      xmax_q  <= '0;
      ymin_q  <= Y_MAXV;
      ymax_q  <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      found_q <= 1'b0;
      fgc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dark_q  <= dark_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      found_q <= found_d;
      fgc_q   <= fgc_d;
      out_q   <= out_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign result_valid = rv_q;
  assign found        = found_q;
  assign fg_count     = fgc_q;
  assign out          = out_q;

endmodule

// File: tb/tb_bbox_scanner.sv
// Bench for bbox_scanner: three instances (default 160x90x3, 16x9x3 bottom-up, 4x3x1 top-down) with a reference box model.
module tb_bbox_scanner;

  typedef struct {
    bit          found;
    logic [31:0] box;
    int          cnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  start, wr_en, rd_en;
  logic [7:0]  wr_data;
  logic        any_mode;
  logic [2:0]  busy, rv, found;
  logic [13:0] cnt0;
  logic [7:0]  cnt1;
  logic [3:0]  cnt2;
  logic [31:0] out0, out1, out2;

  logic [7:0]  frame_mem [0:43199];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;

  bbox_scanner u0 (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[0]), .wr_en(wr_en[0]), .wr_data(wr_data),
    .any_mode(any_mode), .rd_en(rd_en[0]), .busy(busy[0]), .result_valid(rv[0]), .found(found[0]),
    .fg_count(cnt0), .out(out0));

  bbox_scanner #(.WIDTH(16), .HEIGHT(9), .CHANNELS(3), .BOTTOM_UP(1)) u1 (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[1]), .wr_en(wr_en[1]), .wr_data(wr_data),
    .any_mode(any_mode), .rd_en(rd_en[1]), .busy(busy[1]), .result_valid(rv[1]), .found(found[1]),
    .fg_count(cnt1), .out(out1));

  bbox_scanner #(.WIDTH(4), .HEIGHT(3), .CHANNELS(1), .BOTTOM_UP(0)) u2 (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[2]), .wr_en(wr_en[2]), .wr_data(wr_data),
    .any_mode(any_mode), .rd_en(rd_en[2]), .busy(busy[2]), .result_valid(rv[2]), .found(found[2]),
    .fg_count(cnt2), .out(out2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] get_out(input int sel);
    return (sel == 0) ? out0 : (sel == 1) ? out1 : out2;
  endfunction

  function automatic int get_cnt(input int sel);
    return (sel == 0) ? int'(cnt0) : (sel == 1) ? int'(cnt1) : int'(cnt2);
  endfunction

  // Reference: scan frame_mem as a w x h x c frame and return the expected box/count.
  function automatic exp_t model(input int w, input int h, input int c, input bit bu, input bit anym);
    exp_t e;
    int   xmin, xmax, ymin, ymax, n, x, y;
    bit   d, dk;
    xmin = w - 1; xmax = 0; ymin = h - 1; ymax = 0; n = 0;
    for (int p = 0; p < w * h; p++) begin
      x = p % w;
      y = bu ? (h - 1 - p / w) : (p / w);
      d = !anym;
      for (int ch = 0; ch < c; ch++) begin
        dk = frame_mem[p * c + ch] < 8'd100;
        d  = anym ? (d | dk) : (d & dk);
      end
      if (d) begin
        n++;
        if (x < xmin) xmin = x;
        if (x > xmax) xmax = x;
        if (y < ymin) ymin = y;
        if (y > ymax) ymax = y;
      end
    end
    e.found = (n != 0);
    e.box   = (n != 0) ? {8'(xmin), 8'(xmax), 8'(ymin), 8'(ymax)} : 32'd0;
    e.cnt   = n;
    return e;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 43200; i++) frame_mem[i] = v;
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic pulse_rd(input int sel);
    @(negedge clk);
    rd_en[sel] = 1'b1;
    @(negedge clk);
    rd_en[sel] = 1'b0;
  endtask

  task automatic send_bytes(input int sel, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        @(negedge clk);
        wr_en[sel] = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(negedge clk);
      wr_en[sel] = 1'b1;
      wr_data    = frame_mem[i];
    end
    @(negedge clk);
    wr_en[sel] = 1'b0;
  endtask

  task automatic collect(input int sel, output bit ok, output bit f, output logic [31:0] o, output int c);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rv[sel]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    f = found[sel];
    o = get_out(sel);
    c = get_cnt(sel);
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #4;
    for (int s = 0; s < 3; s++) begin
      n_checks += 4;
      if (rv[s] !== 1'b0 || busy[s] !== 1'b0) begin
        n_fails++; $display("FAIL reset_flags[%0d]: rv=%b busy=%b required 0 0", s, rv[s], busy[s]);
      end
      if (found[s] !== 1'b0) begin
        n_fails++; $display("FAIL reset_found[%0d]: got %b required 0", s, found[s]);
      end
      if (get_out(s) !== 32'd0) begin
        n_fails++; $display("FAIL reset_out[%0d]: got %h required 0", s, get_out(s));
      end
      if (get_cnt(s) !== 0) begin
        n_fails++; $display("FAIL reset_cnt[%0d]: got %0d required 0", s, get_cnt(s));
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_default_single_pixel;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    any_mode = 1'b1;
    fill(8'd255);
    frame_mem[3 * (10 + 160 * 5)] = 8'd50;
    sb.push_back(model(160, 90, 3, 1'b1, 1'b1));
    pulse_start(0);
    send_bytes(0, 43200, 1'b0);
    collect(0, ok, f, o, c);
    e = sb.pop_front();
    n_checks += 5;
    if (!ok) begin n_fails++; $display("FAIL dflt_timeout: result_valid=0 required 1"); end
    if (f !== e.found) begin n_fails++; $display("FAIL dflt_found: got %b required %b", f, e.found); end
    if (o !== e.box) begin n_fails++; $display("FAIL dflt_out: got %h required %h", o, e.box); end
    if (o !== {8'd10, 8'd10, 8'd84, 8'd84}) begin
      n_fails++; $display("FAIL dflt_out_const: got %h required 0a0a5454", o);
    end
    if (c !== e.cnt) begin n_fails++; $display("FAIL dflt_cnt: got %0d required %0d", c, e.cnt); end
    pulse_rd(0);
    n_checks += 2;
    if (rv[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fails++; $display("FAIL dflt_rd: rv=%b busy=%b required 0 0", rv[0], busy[0]);
    end
    if (out0 !== e.box) begin n_fails++; $display("FAIL dflt_rd_hold: got %h required %h", out0, e.box); end
  endtask

  task automatic test_white_frame;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    any_mode = 1'b1;
    fill(8'd255);
    sb.push_back(model(16, 9, 3, 1'b1, 1'b1));
    pulse_start(1);
    send_bytes(1, 432, 1'b1);
    collect(1, ok, f, o, c);
    e = sb.pop_front();
    n_checks += 4;
    if (!ok) begin n_fails++; $display("FAIL white_timeout: result_valid=0 required 1"); end
    if (f !== e.found) begin n_fails++; $display("FAIL white_found: got %b required %b", f, e.found); end
    if (o !== e.box) begin n_fails++; $display("FAIL white_out: got %h required %h", o, e.box); end
    if (c !== e.cnt) begin n_fails++; $display("FAIL white_cnt: got %0d required %0d", c, e.cnt); end
    pulse_rd(1);
  endtask

  task automatic test_any_all;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    fill(8'd255);
    frame_mem[3 * 35 + 0] = 8'd10; frame_mem[3 * 35 + 1] = 8'd20; frame_mem[3 * 35 + 2] = 8'd30;
    frame_mem[3 * 124] = 8'd50;
    for (int m = 1; m >= 0; m--) begin
      any_mode = m[0];
      sb.push_back(model(16, 9, 3, 1'b1, m[0]));
      pulse_start(1);
      send_bytes(1, 432, 1'b1);
      collect(1, ok, f, o, c);
      e = sb.pop_front();
      n_checks += 4;
      if (!ok) begin n_fails++; $display("FAIL anyall_timeout[%0d]: result_valid=0 required 1", m); end
      if (f !== e.found) begin n_fails++; $display("FAIL anyall_found[%0d]: got %b required %b", m, f, e.found); end
      if (o !== e.box) begin n_fails++; $display("FAIL anyall_out[%0d]: got %h required %h", m, o, e.box); end
      if (c !== e.cnt) begin n_fails++; $display("FAIL anyall_cnt[%0d]: got %0d required %0d", m, c, e.cnt); end
      pulse_rd(1);
    end
    any_mode = 1'b1;
  endtask

  task automatic test_restart;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    logic [31:0] held;
    held = {8'd3, 8'd3, 8'd6, 8'd6};
    fill(8'd0);
    pulse_start(1);
    send_bytes(1, 100, 1'b0);
    pulse_start(1);
    n_checks += 2;
    if (busy[1] !== 1'b1 || rv[1] !== 1'b0) begin
      n_fails++; $display("FAIL restart_state: busy=%b rv=%b required 1 0", busy[1], rv[1]);
    end
    if (out1 !== held) begin n_fails++; $display("FAIL restart_hold: got %h required %h", out1, held); end
    fill(8'd255);
    sb.push_back(model(16, 9, 3, 1'b1, 1'b1));
    send_bytes(1, 432, 1'b1);
    collect(1, ok, f, o, c);
    e = sb.pop_front();
    n_checks += 4;
    if (!ok) begin n_fails++; $display("FAIL restart_timeout: result_valid=0 required 1"); end
    if (f !== e.found) begin n_fails++; $display("FAIL restart_found: got %b required %b", f, e.found); end
    if (o !== e.box) begin n_fails++; $display("FAIL restart_out: got %h required %h", o, e.box); end
    if (c !== e.cnt) begin n_fails++; $display("FAIL restart_cnt: got %0d required %0d", c, e.cnt); end
    pulse_rd(1);
  endtask

  task automatic test_small_frame;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    fill(8'd255);
    frame_mem[0]  = 8'd0;
    frame_mem[11] = 8'd99;
    sb.push_back(model(4, 3, 1, 1'b0, 1'b1));
    pulse_start(2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 11) begin
        n_checks++;
        if (rv[2] !== 1'b0) begin n_fails++; $display("FAIL small_early: rv=%b required 0", rv[2]); end
      end
      wr_en[2] = 1'b1;
      wr_data  = frame_mem[i];
    end
    @(negedge clk);
    wr_en[2] = 1'b0;
    e = sb.pop_front();
    n_checks += 4;
    if (rv[2] !== 1'b1) begin n_fails++; $display("FAIL small_latency: rv=%b required 1", rv[2]); end
    if (found[2] !== e.found) begin n_fails++; $display("FAIL small_found: got %b required %b", found[2], e.found); end
    if (out2 !== e.box) begin n_fails++; $display("FAIL small_out: got %h required %h", out2, e.box); end
    if (int'(cnt2) !== e.cnt) begin n_fails++; $display("FAIL small_cnt: got %0d required %0d", cnt2, e.cnt); end
    // Restart straight out of DONE with a byte presented alongside start: that byte must be dropped.
    @(negedge clk);
    start[2] = 1'b1; wr_en[2] = 1'b1; wr_data = 8'd0;
    @(negedge clk);
    start[2] = 1'b0; wr_en[2] = 1'b0;
    n_checks += 2;
    if (busy[2] !== 1'b1 || rv[2] !== 1'b0) begin
      n_fails++; $display("FAIL small_restart: busy=%b rv=%b required 1 0", busy[2], rv[2]);
    end
    if (out2 !== e.box) begin n_fails++; $display("FAIL small_hold: got %h required %h", out2, e.box); end
    fill(8'd255);
    frame_mem[5] = 8'd1;
    sb.push_back(model(4, 3, 1, 1'b0, 1'b1));
    send_bytes(2, 12, 1'b1);
    collect(2, ok, f, o, c);
    e = sb.pop_front();
    n_checks += 3;
    if (!ok) begin n_fails++; $display("FAIL drop_timeout: result_valid=0 required 1"); end
    if (o !== e.box) begin n_fails++; $display("FAIL drop_out: got %h required %h", o, e.box); end
    if (c !== e.cnt) begin n_fails++; $display("FAIL drop_cnt: got %0d required %0d", c, e.cnt); end
  endtask

  task automatic test_reset_mid_scan;
    bit ok, f; logic [31:0] o; int c; exp_t e;
    fill(8'd255);
    pulse_start(2);
    send_bytes(2, 5, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (busy[2] !== 1'b0 || rv[2] !== 1'b0 || found[2] !== 1'b0) begin
      n_fails++; $display("FAIL midrst_flags: busy=%b rv=%b found=%b required 0 0 0", busy[2], rv[2], found[2]);
    end
    if (out2 !== 32'd0) begin n_fails++; $display("FAIL midrst_out: got %h required 0", out2); end
    if (cnt2 !== 4'd0) begin n_fails++; $display("FAIL midrst_cnt: got %0d required 0", cnt2); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_bytes(2, 12, 1'b0);
    n_checks++;
    if (busy[2] !== 1'b0 || rv[2] !== 1'b0) begin
      n_fails++; $display("FAIL midrst_ignore: busy=%b rv=%b required 0 0", busy[2], rv[2]);
    end
    frame_mem[2] = 8'd7; frame_mem[9] = 8'd7;
    sb.push_back(model(4, 3, 1, 1'b0, 1'b1));
    pulse_start(2);
    send_bytes(2, 12, 1'b1);
    collect(2, ok, f, o, c);
    e = sb.pop_front();
    n_checks += 3;
    if (!ok) begin n_fails++; $display("FAIL midrst_timeout: result_valid=0 required 1"); end
    if (o !== e.box) begin n_fails++; $display("FAIL midrst_box: got %h required %h", o, e.box); end
    if (c !== e.cnt) begin n_fails++; $display("FAIL midrst_fcnt: got %0d required %0d", c, e.cnt); end
    pulse_rd(2);
    n_checks += 2;
    if (rv[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_fails++; $display("FAIL midrst_rd: rv=%b busy=%b required 0 0", rv[2], busy[2]);
    end
    if (out2 !== e.box) begin n_fails++; $display("FAIL midrst_rd_hold: got %h required %h", out2, e.box); end
  endtask

  initial begin
    start = '0; wr_en = '0; rd_en = '0; wr_data = '0; any_mode = 1'b1;
    test_reset;
    test_default_single_pixel;
    test_white_frame;
    test_any_all;
    test_restart;
    test_small_frame;
    test_reset_mid_scan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
